// File: rtl/fpgaboy_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fpgaboy_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate requests so the slot after last_grant
// is bit 0, priority-encode the lowest set bit, then rotate the result back.
module rr_pick
  import fpgaboy_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic          found,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  grant
);

  logic [N-1:0] rot;

  always_comb begin
    int start;
    int pos;
    int win;
    start = (int'(last_grant) + 1) % int'(N);
    rot   = '0;
    found = 1'b0;
    pos   = 0;
    win   = 0;
    idx   = '0;
    grant = '0;
    for (int k = 0; k < int'(N); k++) begin
      rot[k] = req[(start + k) % int'(N)];
    end
    // Descending scan so the lowest rotated position is the one that sticks.
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pos   = k;
        found = 1'b1;
      end
    end
    if (found) begin
      win   = (start + pos) % int'(N);
      idx   = IW'(win);
      grant = N'(1) << win;
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers, with
// packet locking so multi-beat packets stay contiguous; beats are tagged with the source index.
module fifo_write_arbiter
  import fpgaboy_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned ID_W      = id_width(NUM_REQ),
  localparam int unsigned OCC_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
  input  logic [NUM_REQ-1:0]            req_last_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  input  logic [OCC_W-1:0]              fifo_occupancy_in,
  output logic                          fifo_wr_en_out,
  output logic [ID_W+DATA_WIDTH-1:0]    fifo_data_out,
  output logic                          busy_out,
  output logic [ID_W-1:0]               owner_out
);

  arb_state_t state_q, state_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [ID_W-1:0] owner_q, owner_d;

  logic                  space;
  logic                  pick_found;
  logic [ID_W-1:0]       pick_idx;
  logic [NUM_REQ-1:0]    pick_grant;
  logic [NUM_REQ-1:0]    owner_oh;
  logic [ID_W-1:0]       win_idx;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  win_last;
  logic                  accept;

  // Occupancy is registered in the FIFO, so it already counts last cycle's write.
  assign space = fifo_occupancy_in < OCC_W'(FIFO_DEPTH);

  rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .req        (req_valid_in),
    .last_grant (last_grant_q),
    .found      (pick_found),
    .idx        (pick_idx),
    .grant      (pick_grant)
  );

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      owner_oh[i] = (owner_q == ID_W'(i));
    end
  end

  always_comb begin
    req_ready_out = '0;
    win_idx       = '0;
    if (!rst_in && space) begin
      if (state_q == ARB_LOCKED) begin
        req_ready_out = owner_oh & req_valid_in;
        win_idx       = owner_q;
      end else if (pick_found) begin
        req_ready_out = pick_grant;
        win_idx       = pick_idx;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (win_idx == ID_W'(i)) begin
        win_data = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign accept         = |req_ready_out;
  assign win_last       = |(req_ready_out & req_last_in);
  assign fifo_wr_en_out = accept;
  assign fifo_data_out  = accept ? {win_idx, win_data} : '0;
  assign busy_out       = (state_q == ARB_LOCKED);
  assign owner_out      = busy_out ? owner_q : '0;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    if (accept) begin
      last_grant_d = win_idx;
      unique case (state_q)
        ARB_IDLE: begin
          if (!win_last) begin
            state_d = ARB_LOCKED;
            owner_d = win_idx;
          end
        end
        ARB_LOCKED: begin
          if (win_last) begin
            state_d = ARB_IDLE;
            owner_d = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      owner_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
    end
  end

endmodule
